// File: rtl/cmd_issue_queue.sv
// cmd_issue_queue: in-order command FIFO with request/ack issue, timed retry backoff and drop after MAX_RETRY refusals.
module cmd_issue_queue #(
   parameter int DEPTH     = 8,
   parameter int RETRY_GAP = 4,
   parameter int MAX_RETRY = 15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [5:0]                 in_addr,
   input  logic [31:0]                in_data,
   output logic                       in_ready,
   output logic [5:0]                 cmd_addr,
   output logic [31:0]                cmd_data,
   output logic                       cmd_rqst,
   input  logic                       cmd_ack,
   output logic                       drop_pulse,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [7:0] RMAX = 8'(MAX_RETRY - 1);
   typedef enum logic [1:0] {IDLE, RQST, CHECK, BACKOFF} state_t;
   state_t state, state_nxt;
   logic [37:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_q;
   logic [7:0] retry, retry_nxt, gap, gap_nxt;
   logic rdy, push, pop, drop;
   assign in_ready = rdy & (level_q != LW'(DEPTH));
   assign push = in_valid & in_ready;
   assign level = level_q;
   assign {cmd_addr, cmd_data} = (level_q != '0) ? mem[rd_ptr] : '0;
   assign cmd_rqst = (state == RQST);
   assign drop_pulse = drop & rst_n;
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_addr, in_data};
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         rdy     <= 1'b0;
         retry   <= '0;
         gap     <= '0;
      end else begin
         state   <= state_nxt;
         retry   <= retry_nxt;
         gap     <= gap_nxt;
         rdy     <= 1'b1;
         level_q <= level_q + LW'(push) - LW'(pop);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
   end
   // the last tolerated refusal pops the head exactly like an acceptance, but flags it as dropped
   always_comb begin
      state_nxt = state;
      retry_nxt = retry;
      gap_nxt   = gap;
      pop       = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE:  state_nxt = (level_q != '0) ? RQST : IDLE;
         RQST:  state_nxt = CHECK;
         CHECK: begin
            if (cmd_ack || retry == RMAX) begin
               pop       = 1'b1;
               drop      = ~cmd_ack;
               retry_nxt = '0;
               state_nxt = IDLE;
            end else begin
               retry_nxt = retry + 8'd1;
               gap_nxt   = 8'(RETRY_GAP);
               state_nxt = BACKOFF;
            end
         end
         BACKOFF: begin
            gap_nxt   = gap - 8'd1;
            state_nxt = (gap == 8'd1) ? RQST : BACKOFF;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cmd_issue_queue.sv
// tb_cmd_issue_queue: directed checks of issue timing, retry/drop, full handling and mid-flight reset.
module tb_cmd_issue_queue;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic [5:0] in_addr = '0;
   logic [31:0] in_data = '0;
   logic in_ready;
   logic [5:0] cmd_addr;
   logic [31:0] cmd_data;
   logic cmd_rqst;
   logic cmd_ack = 1'b0;
   logic drop_pulse;
   logic [3:0] level;
   int n_checks = 0;
   int n_err = 0;
   int cyc = 0;
   int rq_n = 0;
   int drops = 0;
   int drop_t = 0;
   int rq_t [128];
   logic [5:0] rq_a [128];
   logic [31:0] rq_d [128];
   logic plan [128];
   logic hold = 1'b0;
   cmd_issue_queue dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
      .in_ready(in_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rqst(cmd_rqst),
      .cmd_ack(cmd_ack), .drop_pulse(drop_pulse), .level(level)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // slave model: answers each request from plan[], holding ack through the following cycle
   always @(negedge clk) begin
      if (drop_pulse === 1'b1) begin
         drops++;
         drop_t = cyc;
      end
      if (cmd_rqst === 1'b1) begin
         rq_t[rq_n] = cyc;
         rq_a[rq_n] = cmd_addr;
         rq_d[rq_n] = cmd_data;
         cmd_ack = plan[rq_n];
         hold = 1'b1;
         rq_n++;
      end else if (hold) hold = 1'b0;
      else cmd_ack = 1'b0;
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_rq(input int n);
      int k = 0;
      while (rq_n < n && k < 300) begin
         @(posedge clk);
         k++;
      end
      check("rq_count", rq_n, n);
   endtask
   int b;
   int bad;
   initial begin
      for (int i = 0; i < 128; i++) plan[i] = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_level", level, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_rqst", cmd_rqst, 0);
      check("rst_drop", drop_pulse, 0);
      check("rst_addr", cmd_addr, 0);
      check("rst_data", cmd_data, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", in_ready, 1);
      // single command, accepted on first try
      in_valid = 1'b1; in_addr = 6'h09; in_data = 32'h5000_0000;
      @(negedge clk);
      in_valid = 1'b0;
      check("s1_level", level, 1);
      check("s1_no_rqst", cmd_rqst, 0);
      @(negedge clk);
      check("s1_rqst", cmd_rqst, 1);
      check("s1_addr", cmd_addr, 6'h09);
      check("s1_data", cmd_data, 32'h5000_0000);
      @(negedge clk);
      check("s1_rqst_one", cmd_rqst, 0);
      check("s1_level_chk", level, 1);
      @(negedge clk);
      check("s1_level_pop", level, 0);
      check("s1_addr_empty", cmd_addr, 0);
      // three back-to-back commands, always accepted
      b = rq_n;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_addr = 6'(i + 1); in_data = 32'hA0 + 32'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_rq(b + 3);
      @(negedge clk);
      for (int i = 0; i < 3; i++) check("s2_order", rq_a[b + i], 6'(i + 1));
      check("s2_gap01", rq_t[b + 1] - rq_t[b], 3);
      check("s2_gap12", rq_t[b + 2] - rq_t[b + 1], 3);
      repeat (3) @(negedge clk);
      check("s2_level", level, 0);
      // refused twice then accepted
      b = rq_n;
      plan[b] = 1'b0; plan[b + 1] = 1'b0;
      in_valid = 1'b1; in_addr = 6'h05; in_data = 32'hDEAD_BEEF;
      @(negedge clk);
      in_valid = 1'b0;
      wait_rq(b + 3);
      @(negedge clk);
      check("s3_gap01", rq_t[b + 1] - rq_t[b], 6);
      check("s3_gap12", rq_t[b + 2] - rq_t[b + 1], 6);
      check("s3_addr", {rq_a[b + 1], rq_a[b + 2]}, {6'h05, 6'h05});
      check("s3_data", {rq_d[b], rq_d[b + 2]}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
      repeat (10) @(negedge clk);
      check("s3_level", level, 0);
      check("s3_single_pop", rq_n, b + 3);
      check("s3_no_drop", drops, 0);
      // always refused: head dropped after 15 tries, next command issued
      b = rq_n;
      for (int i = 0; i < 15; i++) plan[b + i] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_addr = 6'h10 + 6'(i); in_data = 32'hC0 + 32'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_rq(b + 16);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 15; i++) if (rq_a[b + i] != 6'h10) bad++;
      check("s4_head_addr", bad, 0);
      check("s4_next_addr", rq_a[b + 15], 6'h11);
      check("s4_drops", drops, 1);
      check("s4_drop_time", drop_t, rq_t[b + 14] + 1);
      check("s4_gap_last", rq_t[b + 15] - rq_t[b + 14], 3);
      repeat (3) @(negedge clk);
      check("s4_level", level, 0);
      // fill to full while stalled, ninth command waits for a pop
      b = rq_n;
      plan[b] = 1'b0; plan[b + 1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_addr = 6'h20 + 6'(i); in_data = 32'hB0 + 32'(i);
         @(negedge clk);
      end
      in_addr = 6'h28; in_data = 32'hB8;
      check("s5_full_level", level, 8);
      check("s5_full_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      check("s5_no_push", level, 8);
      wait_rq(b + 3);
      @(negedge clk);
      check("s5_pop_level", level, 8);
      check("s5_pop_ready", in_ready, 0);
      @(negedge clk);
      check("s5_freed_level", level, 7);
      check("s5_freed_ready", in_ready, 1);
      check("s5_new_head", cmd_addr, 6'h21);
      @(negedge clk);
      in_valid = 1'b0;
      check("s5_refill", level, 8);
      wait_rq(b + 11);
      @(negedge clk);
      check("s5_last_addr", rq_a[b + 10], 6'h28);
      check("s5_last_data", rq_d[b + 10], 32'hB8);
      repeat (3) @(negedge clk);
      check("s5_drained", level, 0);
      // reset during backoff with three commands queued
      b = rq_n;
      for (int i = 0; i < 6; i++) plan[b + i] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_addr = 6'h30 + 6'(i); in_data = 32'hE0 + 32'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      wait_rq(b + 1);
      @(negedge clk);
      @(negedge clk);
      check("s6_backoff_level", level, 3);
      rst_n = 1'b0;
      @(negedge clk);
      check("s6_rst_level", level, 0);
      check("s6_rst_rqst", cmd_rqst, 0);
      check("s6_rst_drop", drop_pulse, 0);
      check("s6_rst_ready", in_ready, 0);
      check("s6_rst_addr", cmd_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("s6_rel_ready", in_ready, 1);
      repeat (8) @(negedge clk);
      check("s6_no_rqst", rq_n, b + 1);
      check("s6_drops", drops, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
